// File: rtl/puf_pkg.sv
// Shared types and constants for the RO-PUF response generator.
// The stability-mask feature is selected with the PUF_STABILITY_MASK_EN macro.
package puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } puf_state_e;

  localparam int PUF_COUNT_W_DEF   = 32;
  localparam int PUF_RESP_BITS_DEF = 16;

  // The index must be able to hold RESP_BITS itself, since it is left at the full count in DONE.
  function automatic int idx_width(input int resp_bits);
    return (resp_bits < 1) ? 1 : $clog2(resp_bits + 1);
  endfunction

endpackage

// File: rtl/puf_pair_cmp.sv
// Combinational comparator for one ring-oscillator count pair.
// With PUF_STABILITY_MASK_EN it also flags pairs whose distance is below MARGIN.
module puf_pair_cmp #(
  parameter int COUNT_W = 32
`ifdef PUF_STABILITY_MASK_EN
  ,
  parameter int MARGIN  = 4
`endif
) (
  input  logic [COUNT_W-1:0] count1,
  input  logic [COUNT_W-1:0] count2,
  output logic               cmp_bit,
  output logic               unstable
);

`ifdef PUF_STABILITY_MASK_EN
  localparam logic [COUNT_W:0] MARGIN_EXT = (COUNT_W + 1)'(MARGIN);

  logic             gt_s;
  logic [COUNT_W:0] mag_s;

  // Magnitude is taken one bit wider than the counts so the extremes cannot wrap.
  always_comb begin
    gt_s = (count2 > count1);
    if (gt_s) begin
      mag_s = {1'b0, count2} - {1'b0, count1};
    end else begin
      mag_s = {1'b0, count1} - {1'b0, count2};
    end
    cmp_bit  = gt_s;
    unstable = (mag_s < MARGIN_EXT);
  end
`else
  // Plain ordering compare; no magnitude logic in this build.
  always_comb begin
    cmp_bit  = (count1 < count2);
    unstable = 1'b0;
  end
`endif

endmodule

// File: rtl/puf_response_gen.sv
// RO-PUF response generator: collects RESP_BITS compared count pairs into one word.
// Optional per-bit stability mask enabled by the PUF_STABILITY_MASK_EN macro.
module puf_response_gen
  import puf_pkg::*;
#(
  parameter int COUNT_W   = PUF_COUNT_W_DEF,
  parameter int RESP_BITS = PUF_RESP_BITS_DEF
`ifdef PUF_STABILITY_MASK_EN
  ,
  parameter int MARGIN    = 4
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [COUNT_W-1:0]                  count1,
  input  logic [COUNT_W-1:0]                  count2,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [RESP_BITS-1:0]                response,
  output logic [RESP_BITS-1:0]                unstable_mask,
  output logic [idx_width(RESP_BITS)-1:0]     bit_idx
);

  localparam int              IDX_W    = idx_width(RESP_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

  puf_state_e           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 in_ready_q, in_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [RESP_BITS-1:0] response_q, response_d;
  logic [RESP_BITS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 cmp_bit_s;
  logic                 unstable_s;

  puf_pair_cmp #(
    .COUNT_W (COUNT_W)
`ifdef PUF_STABILITY_MASK_EN
    ,
    .MARGIN  (MARGIN)
`endif
  ) u_pair_cmp (
    .count1   (count1),
    .count2   (count2),
    .cmp_bit  (cmp_bit_s),
    .unstable (unstable_s)
  );

  // Next-state, index and word assembly; status flags are decoded from the next state.
  always_comb begin
    state_d    = state_q;
    response_d = response_q;
    mask_d     = mask_q;
    bit_idx_d  = bit_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          response_d = '0;
          mask_d     = '0;
          bit_idx_d  = '0;
          state_d    = ST_COLLECT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (in_valid) begin
          for (int i = 0; i < RESP_BITS; i++) begin
            if (bit_idx_q == IDX_W'(i)) begin
              response_d[i] = cmp_bit_s;
              mask_d[i]     = unstable_s;
            end else begin
              response_d[i] = response_q[i];
              mask_d[i]     = mask_q[i];
            end
          end
          bit_idx_d = bit_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          if (bit_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d       = (state_d != ST_IDLE);
    in_ready_d   = (state_d == ST_COLLECT);
    resp_valid_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      response_q   <= '0;
      mask_q       <= '0;
      bit_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      resp_valid_q <= resp_valid_d;
      response_q   <= response_d;
      mask_q       <= mask_d;
      bit_idx_q    <= bit_idx_d;
    end
  end

  assign busy          = busy_q;
  assign in_ready      = in_ready_q;
  assign resp_valid    = resp_valid_q;
  assign response      = response_q;
  assign unstable_mask = mask_q;
  assign bit_idx       = bit_idx_q;

endmodule

// File: tb/tb_puf_response_gen.sv
// Directed self-checking bench for puf_response_gen with RESP_BITS=4, COUNT_W=32.
// Mask expectations follow PUF_STABILITY_MASK_EN (MARGIN=4 when defined).
module tb_puf_response_gen;

  localparam int CW = 32;
  localparam int RB = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] count1 = '0;
  logic [CW-1:0] count2 = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [RB-1:0] response;
  logic [RB-1:0] unstable_mask;
  logic [IW-1:0] bit_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  puf_response_gen #(
    .COUNT_W   (CW),
    .RESP_BITS (RB)
`ifdef PUF_STABILITY_MASK_EN
    ,
    .MARGIN    (4)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .count1        (count1),
    .count2        (count2),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .response      (response),
    .unstable_mask (unstable_mask),
    .bit_idx       (bit_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] a, input logic [CW-1:0] b);
    count1   = a;
    count2   = b;
    in_valid = 1'b1;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [RB-1:0] mexp(input logic [RB-1:0] m);
`ifdef PUF_STABILITY_MASK_EN
    return m;
`else
    return (m & 4'b0000);
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_response", response, 4'h0);
    chk("rst_mask", unstable_mask, 4'h0);
    chk("rst_idx", bit_idx, 3'd0);

    // Basic word
    do_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_in_ready", in_ready, 1'b1);
    send(32'd100, 32'd50);
    chk("t1_idx1", bit_idx, 3'd1);
    send(32'd20, 32'd80);
    send(32'd55, 32'd52);
    chk("t1_not_valid_yet", resp_valid, 1'b0);
    send(32'd7, 32'd7);
    in_valid = 1'b0;
    chk("t1_resp_valid", resp_valid, 1'b1);
    chk("t1_in_ready_done", in_ready, 1'b0);
    chk("t1_response", response, 4'b0010);
    chk("t1_mask", unstable_mask, mexp(4'b1100));
    chk("t1_idx4", bit_idx, 3'd4);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("t1_idle_valid", resp_valid, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_held_resp", response, 4'b0010);

    // Stability
    do_start();
    chk("t2_cleared", response, 4'h0);
    send(32'd100, 32'd98);
    send(32'd10, 32'd40);
    send(32'd5, 32'd5);
    send(32'd0, 32'd3);
    in_valid = 1'b0;
    chk("t2_response", response, 4'b1010);
    chk("t2_mask", unstable_mask, mexp(4'b1101));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Extremes
    do_start();
    send(32'hFFFF_FFFF, 32'h0);
    send(32'h0, 32'hFFFF_FFFF);
    chk("t3_partial", response[1:0], 2'b10);
    chk("t3_partial_mask", unstable_mask[1:0], 2'b00);
    send(32'd1, 32'd2);
    send(32'd9, 32'd3);
    in_valid = 1'b0;
    chk("t3_response", response, 4'b0110);
    chk("t3_mask", unstable_mask, mexp(4'b0100));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Backpressure and stalls
    do_start();
    send(32'd3, 32'd9);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      step();
      chk("t4_gap_idx", bit_idx, 3'd1);
      chk("t4_gap_resp", response, 4'b0001);
      chk("t4_gap_busy", busy, 1'b1);
    end
    start = 1'b0;
    send(32'd9, 32'd3);
    send(32'd4, 32'd4);
    send(32'd0, 32'd100);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i[0] == 1'b0);
      step();
      chk("t4_hold_valid", resp_valid, 1'b1);
      chk("t4_hold_resp", response, 4'b1001);
      chk("t4_hold_mask", unstable_mask, mexp(4'b0100));
      chk("t4_hold_idx", bit_idx, 3'd4);
    end
    start = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("t4_released", resp_valid, 1'b0);

    // Reset mid-collect
    do_start();
    send(32'd0, 32'd10);
    send(32'd0, 32'd10);
    chk("t5_partial", response, 4'b0011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_in_ready", in_ready, 1'b0);
    chk("t5_resp_valid", resp_valid, 1'b0);
    chk("t5_response", response, 4'h0);
    chk("t5_mask", unstable_mask, 4'h0);
    chk("t5_idx", bit_idx, 3'd0);
    step();
    chk("t5_stays_idle", busy, 1'b0);
    do_start();
    send(32'd5, 32'd1);
    send(32'd1, 32'd5);
    send(32'd2, 32'd3);
    send(32'd8, 32'd0);
    in_valid = 1'b0;
    chk("t5_fresh_resp", response, 4'b0110);
    chk("t5_fresh_mask", unstable_mask, mexp(4'b0100));
    chk("t5_fresh_valid", resp_valid, 1'b1);

    // resp_ready already high on DONE entry
    resp_ready = 1'b1;
    step();
    chk("t6_prev_done", resp_valid, 1'b0);
    do_start();
    send(32'd1, 32'd0);
    send(32'd0, 32'd1);
    send(32'd0, 32'd1);
    send(32'd0, 32'd1);
    in_valid = 1'b0;
    chk("t6_valid_pulse", resp_valid, 1'b1);
    chk("t6_response", response, 4'b1110);
    start = 1'b1;
    step();
    chk("t6_valid_drop", resp_valid, 1'b0);
    chk("t6_idle", busy, 1'b0);
    step();
    start = 1'b0;
    resp_ready = 1'b0;
    chk("t6_restart_busy", busy, 1'b1);
    chk("t6_restart_ready", in_ready, 1'b1);
    chk("t6_restart_idx", bit_idx, 3'd0);
    chk("t6_restart_resp", response, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
